// File: rtl/viterbi_traceback_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
// Shared definitions for the Viterbi traceback block: default sizing,
// scalar types for states / metrics / timestep indices, the traceback FSM
// state enum, and an index-width helper used to size ports and registers.
// -----------------------------------------------------------------------------
package viterbi_pkg;

    localparam int DEF_I     = 3;   // number of HMM states
    localparam int DEF_W     = 20;  // signed path-metric width
    localparam int DEF_T_MAX = 16;  // traceback buffer depth

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(DEF_I)-1:0]     state_t;
    typedef logic signed [DEF_W-1:0]      score_t;
    typedef logic [$clog2(DEF_T_MAX)-1:0] tstep_t;

    typedef enum logic {
        FILL,
        TRACE
    } tb_state_e;

endpackage

// File: rtl/viterbi_traceback_if.sv
// -----------------------------------------------------------------------------
// viterbi_traceback_if
// Bundles the two streams of the traceback block.
//   Input stream  (one timestep per beat):
//     in_valid, in_ready, in_last, psi_vec[0:I-1], delta_vec[0:I-1]
//   Output stream (decoded states, newest first):
//     out_valid, out_ready, out_state, out_t, out_last
// Modports:
//   master - the environment (PE array upstream, consumer downstream)
//   slave  - the traceback block itself
// -----------------------------------------------------------------------------
interface viterbi_traceback_if #(
    parameter int I     = viterbi_pkg::DEF_I,
    parameter int W     = viterbi_pkg::DEF_W,
    parameter int T_MAX = viterbi_pkg::DEF_T_MAX
);
    import viterbi_pkg::*;

    localparam int SW = idx_w(I);
    localparam int TW = idx_w(T_MAX);

    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [SW-1:0]       psi_vec   [0:I-1];
    logic signed [W-1:0] delta_vec [0:I-1];

    logic                out_valid;
    logic                out_ready;
    logic [SW-1:0]       out_state;
    logic [TW-1:0]       out_t;
    logic                out_last;

    modport master (
        output in_valid, in_last, psi_vec, delta_vec, out_ready,
        input  in_ready, out_valid, out_state, out_t, out_last
    );

    modport slave (
        input  in_valid, in_last, psi_vec, delta_vec, out_ready,
        output in_ready, out_valid, out_state, out_t, out_last
    );

endinterface

// File: rtl/viterbi_traceback_argmax.sv
// -----------------------------------------------------------------------------
// viterbi_argmax
// Purely combinational argmax over I signed W-bit path metrics.
// Ties resolve to the lowest index (strict greater-than while scanning up).
// Ports:
//   i_delta_vec[0:I-1]  in   signed path metrics
//   o_max               out  winning metric (only when
//                            VITERBI_TRACEBACK_SCORE_EN is defined)
//   o_idx               out  index of the winning metric
// -----------------------------------------------------------------------------
module viterbi_argmax
    import viterbi_pkg::*;
#(
    parameter int I = DEF_I,
    parameter int W = DEF_W
) (
    input  logic signed [W-1:0]    i_delta_vec [0:I-1],
`ifdef VITERBI_TRACEBACK_SCORE_EN
    output logic signed [W-1:0]    o_max,
`endif
    output logic [idx_w(I)-1:0]    o_idx
);

    localparam int SW = idx_w(I);

    logic signed [W-1:0] w_best;
    logic [SW-1:0]       w_idx;

    always_comb begin
        w_best = i_delta_vec[0];
        w_idx  = '0;
        for (int unsigned j = 1; j < I; j++) begin
            if (i_delta_vec[j] > w_best) begin
                w_best = i_delta_vec[j];
                w_idx  = SW'(j);
            end
        end
    end

    assign o_idx = w_idx;
`ifdef VITERBI_TRACEBACK_SCORE_EN
    assign o_max = w_best;
`endif

endmodule

// File: rtl/viterbi_traceback.sv
// -----------------------------------------------------------------------------
// viterbi_traceback
// Consumes one timestep per beat from the viterbi_pe column, buffers the
// backpointers, picks the best end state on the terminating beat and then
// walks the backpointers backwards, streaming decoded states newest first.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   bus           --   viterbi_traceback_if.slave (input + output streams)
//   err_overflow  out  sticky: a sequence reached T_MAX beats without in_last
//   best_score    out  winning end metric (only with
//                      VITERBI_TRACEBACK_SCORE_EN defined)
// Configuration macro: VITERBI_TRACEBACK_SCORE_EN
// -----------------------------------------------------------------------------
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int I     = DEF_I,
    parameter int W     = DEF_W,
    parameter int T_MAX = DEF_T_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    viterbi_traceback_if.slave    bus,
    output logic                  err_overflow
`ifdef VITERBI_TRACEBACK_SCORE_EN
    ,
    output logic signed [W-1:0]   best_score
`endif
);

    localparam int SW = idx_w(I);
    localparam int TW = idx_w(T_MAX);

    tb_state_e           r_state;
    logic [TW-1:0]       r_wr_ptr;
    logic [TW-1:0]       r_rd_ptr;
    logic [SW-1:0]       r_cur_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_err;
    logic [SW-1:0]       r_psi_mem [0:T_MAX-1][0:I-1];
`ifdef VITERBI_TRACEBACK_SCORE_EN
    logic signed [W-1:0] r_best;
    logic signed [W-1:0] w_arg_max;
`endif

    logic [SW-1:0]       w_arg_idx;
    logic [SW-1:0]       w_psi_rd;
    logic                w_accept;
    logic                w_at_end;
    logic                w_terminate;

    viterbi_argmax #(
        .I (I),
        .W (W)
    ) u_argmax (
        .i_delta_vec (bus.delta_vec),
`ifdef VITERBI_TRACEBACK_SCORE_EN
        .o_max       (w_arg_max),
`endif
        .o_idx       (w_arg_idx)
    );

    assign w_accept    = (r_state == FILL) && bus.in_valid;
    assign w_at_end    = (r_wr_ptr == TW'(T_MAX - 1));
    assign w_terminate = bus.in_last || w_at_end;

    // Backpointer lookup for the current state at the current read slot.
    // A state value outside 0..I-1 selects nothing and yields 0.
    always_comb begin
        w_psi_rd = '0;
        for (int unsigned j = 0; j < I; j++) begin
            if (r_cur_state == SW'(j)) begin
                w_psi_rd = r_psi_mem[r_rd_ptr][j];
            end
        end
    end

    // Backpointer buffer: register array, no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int unsigned j = 0; j < I; j++) begin
                r_psi_mem[r_wr_ptr][j] <= bus.psi_vec[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cur_state <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
`ifdef VITERBI_TRACEBACK_SCORE_EN
            r_best      <= '0;
`endif
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (w_terminate) begin
                            if (!bus.in_last) begin
                                r_err <= 1'b1;
                            end
                            r_cur_state <= w_arg_idx;
                            r_rd_ptr    <= r_wr_ptr;
                            r_wr_ptr    <= '0;
                            r_state     <= TRACE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (r_wr_ptr == '0);
`ifdef VITERBI_TRACEBACK_SCORE_EN
                            r_best      <= w_arg_max;
`endif
                        end else begin
                            r_wr_ptr <= r_wr_ptr + TW'(1);
                        end
                    end
                end
                TRACE: begin
                    if (bus.out_ready) begin
                        if (r_rd_ptr != '0) begin
                            r_cur_state <= w_psi_rd;
                            r_rd_ptr    <= r_rd_ptr - TW'(1);
                            r_out_last  <= (r_rd_ptr == TW'(1));
                        end else begin
                            r_state     <= FILL;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_state = r_cur_state;
    assign bus.out_t     = r_rd_ptr;
    assign bus.out_last  = r_out_last;
    assign err_overflow  = r_err;
`ifdef VITERBI_TRACEBACK_SCORE_EN
    assign best_score    = r_best;
`endif

endmodule

// File: tb/tb_viterbi_traceback.sv
// -----------------------------------------------------------------------------
// tb_viterbi_traceback
// Self-checking bench for viterbi_traceback with I=3, W=20, T_MAX=4.
// Hand-computed vector table, backpressure and mid-trace reset sequences,
// then random sequences checked against a behavioural traceback model.
// -----------------------------------------------------------------------------
module tb_viterbi_traceback;

    localparam int I     = 3;
    localparam int W     = 20;
    localparam int T_MAX = 4;

    typedef struct {
        int                 len;
        bit                 last;
        bit                 ovf;
        bit [3:0][2:0][1:0] psi;    // [t][state]
        bit [2:0][19:0]     delta;  // terminating beat metrics
        bit [3:0][1:0]      st;     // expected states, newest first
        bit [19:0]          best;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        err_overflow;
    logic [19:0] best_score;

    int n_vec = 0;
    int n_err = 0;
    bit m_err = 0;

    vec_t vecs [0:5];

    viterbi_traceback_if #(.I(I), .W(W), .T_MAX(T_MAX)) bus ();

    viterbi_traceback #(
        .I     (I),
        .W     (W),
        .T_MAX (T_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .err_overflow (err_overflow)
`ifdef VITERBI_TRACEBACK_SCORE_EN
        ,
        .best_score   (best_score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit [2:0][1:0] p3(input int a, input int b, input int c);
        p3[0] = 2'(a);
        p3[1] = 2'(b);
        p3[2] = 2'(c);
    endfunction

    function automatic bit [2:0][19:0] d3(input int a, input int b, input int c);
        d3[0] = 20'(a);
        d3[1] = 20'(b);
        d3[2] = 20'(c);
    endfunction

    function automatic bit [3:0][1:0] s4(input int a, input int b, input int c, input int d);
        s4[0] = 2'(a);
        s4[1] = 2'(b);
        s4[2] = 2'(c);
        s4[3] = 2'(d);
    endfunction

    function automatic vec_t mkv(input int len, input bit last, input bit ovf, input int best);
        vec_t v;
        v.len   = len;
        v.last  = last;
        v.ovf   = ovf;
        v.psi   = '0;
        v.delta = '0;
        v.st    = '0;
        v.best  = 20'(best);
        return v;
    endfunction

    // Reference: best end state is the highest signed metric (first on ties);
    // each earlier state is the stored predecessor of the later one.
    function automatic vec_t model(input vec_t vin);
        vec_t v;
        int   best;
        int   s;
        int   t;
        int   dj;
        v    = vin;
        best = int'($signed(v.delta[0]));
        s    = 0;
        for (int j = 1; j < I; j++) begin
            dj = int'($signed(v.delta[j]));
            if (dj > best) begin
                best = dj;
                s    = j;
            end
        end
        v.best = 20'(best);
        v.st   = '0;
        for (int k = 0; k < v.len; k++) begin
            t       = v.len - 1 - k;
            v.st[k] = 2'(s);
            if (t > 0) s = int'(v.psi[t][s]);
        end
        v.ovf = (v.len == T_MAX) && !v.last;
        return v;
    endfunction

    task automatic send_beats(input vec_t v);
        for (int t = 0; t < v.len; t++) begin
            check("in_ready_fill", bus.in_ready, 1);
            bus.in_valid = 1'b1;
            bus.in_last  = v.last && (t == v.len - 1);
            for (int j = 0; j < I; j++) begin
                bus.psi_vec[j]   = v.psi[t][j];
                bus.delta_vec[j] = (t == v.len - 1) ? $signed(v.delta[j]) : $signed(20'($urandom));
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (v.ovf) m_err = 1'b1;
        check("err_overflow", err_overflow, m_err);
        check("first_out_valid", bus.out_valid, 1);
`ifdef VITERBI_TRACEBACK_SCORE_EN
        check("best_score", best_score, v.best);
`endif
    endtask

    task automatic collect(input vec_t v, input int stall_at, input bit rnd);
        int          n      = 0;
        int          cyc    = 0;
        int          stalls = 0;
        bit          done   = 1'b0;
        bit          held_v = 1'b0;
        bit          rdy;
        logic [63:0] held   = '0;
        logic [63:0] cur;
        logic [63:0] exp;
        while (!done && cyc < 100) begin
            cur = {59'd0, bus.out_t, bus.out_state, bus.out_last};
            if (held_v) check("hold_stable{t,state,last}", cur, held);
            check("in_ready_trace", bus.in_ready, 0);
            if (stall_at == n && stalls < 3) begin
                rdy = 1'b0;
                stalls++;
            end else if (rnd) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            bus.out_ready = rdy;
            held_v = 1'b0;
            if (bus.out_valid && rdy) begin
                exp = {59'd0, 2'(v.len - 1 - n), v.st[n], 1'(n == v.len - 1)};
                check("out_beat{t,state,last}", cur, exp);
                n++;
                if (n >= v.len) done = 1'b1;
            end else if (bus.out_valid) begin
                held   = cur;
                held_v = 1'b1;
            end else begin
                check("out_valid_trace", bus.out_valid, 1);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("trace_done", done, 1);
        check("out_count", n, v.len);
        check("in_ready_after", bus.in_ready, 1);
        check("out_valid_after", bus.out_valid, 0);
    endtask

    task automatic run_vec(input vec_t v, input int stall_at, input bit rnd);
        send_beats(v);
        collect(v, stall_at, rnd);
    endtask

    initial begin
        vec_t v;

        // Table: inputs and hand-derived expected outputs.
        vecs[0] = mkv(3, 1'b1, 1'b0, 27);
        vecs[0].psi[1] = p3(2, 0, 1);
        vecs[0].psi[2] = p3(1, 2, 0);
        vecs[0].delta  = d3(10, 27, 15);
        vecs[0].st     = s4(1, 2, 1, 0);

        vecs[1] = mkv(1, 1'b1, 1'b0, 5);
        vecs[1].delta  = d3(5, 5, 3);
        vecs[1].st     = s4(0, 0, 0, 0);

        vecs[2] = mkv(2, 1'b1, 1'b0, -3);
        vecs[2].psi[1] = p3(0, 1, 2);
        vecs[2].delta  = d3(-8, -3, -20);
        vecs[2].st     = s4(1, 1, 0, 0);

        vecs[3] = mkv(1, 1'b1, 1'b0, 9);
        vecs[3].delta  = d3(1, 2, 9);
        vecs[3].st     = s4(2, 0, 0, 0);

        vecs[4] = mkv(4, 1'b1, 1'b0, 7);
        vecs[4].psi[1] = p3(1, 1, 1);
        vecs[4].psi[2] = p3(2, 0, 2);
        vecs[4].psi[3] = p3(0, 0, 1);
        vecs[4].delta  = d3(7, -1, 7);
        vecs[4].st     = s4(0, 0, 2, 1);

        vecs[5] = mkv(4, 1'b0, 1'b1, 4);
        vecs[5].psi[1] = p3(1, 1, 1);
        vecs[5].psi[2] = p3(2, 0, 2);
        vecs[5].psi[3] = p3(0, 0, 1);
        vecs[5].delta  = d3(0, 0, 4);
        vecs[5].st     = s4(2, 1, 0, 1);

        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        for (int j = 0; j < I; j++) begin
            bus.psi_vec[j]   = '0;
            bus.delta_vec[j] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_err", err_overflow, 0);
        check("rst_out_t", bus.out_t, 0);
        check("rst_out_state", bus.out_state, 0);
        check("rst_out_last", bus.out_last, 0);
`ifdef VITERBI_TRACEBACK_SCORE_EN
        check("rst_best_score", best_score, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], -1, 1'b0);
        end

        // Backpressure: three stalled cycles after the first output.
        run_vec(vecs[0], 1, 1'b0);

        for (int r = 0; r < 40; r++) begin
            v = mkv($urandom_range(1, T_MAX), 1'b1, 1'b0, 0);
            if (v.len == T_MAX) v.last = 1'($urandom_range(0, 1));
            for (int t = 0; t < T_MAX; t++) begin
                v.psi[t] = p3($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            end
            if ($urandom_range(0, 1) == 1) begin
                v.delta = d3($urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2);
            end else begin
                v.delta = d3($urandom_range(0, 400000) - 200000, $urandom_range(0, 400000) - 200000,
                             $urandom_range(0, 400000) - 200000);
            end
            v = model(v);
            run_vec(v, -1, 1'b1);
        end

        // Reset in the middle of a trace discards it, clears the sticky error.
        send_beats(vecs[0]);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("midtrace_out_valid", bus.out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_out_valid", bus.out_valid, 0);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_err", err_overflow, 0);
        check("post_rst_out_last", bus.out_last, 0);
        m_err = 1'b0;
        run_vec(vecs[0], -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
